// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU instruction sizes, opcode encodings, encoder FSM states and instruction length lookup
package cpu_pkg;
    localparam int cpu_inst_opcode_sz = 5;
    localparam int cpu_inst_regop_sz  = 3;
    localparam int cpu_inst_immop_sz  = 16;
    localparam int cpu_pc_sz          = 16;
    localparam int cpu_code_sz        = 32;
    localparam int cpu_inst_max_len   = cpu_inst_opcode_sz + cpu_inst_regop_sz + cpu_inst_immop_sz;
    localparam int cpu_inst_len_sz    = $clog2(cpu_inst_max_len + 1);

    typedef logic [cpu_inst_opcode_sz-1:0] cpu_opcode_t;
    typedef logic [cpu_inst_len_sz-1:0]    cpu_len_t;
    typedef enum logic {ENC_RUN, ENC_FLUSH} cpu_enc_state_e;

    localparam cpu_opcode_t cpu_inst_opcode_imm = 5'd1;
    localparam cpu_opcode_t cpu_inst_opcode_jmp = 5'd2;
    localparam cpu_opcode_t cpu_inst_opcode_jlt = 5'd3;
    localparam cpu_opcode_t cpu_inst_opcode_jeq = 5'd4;
    localparam cpu_opcode_t cpu_inst_opcode_jgt = 5'd5;
    localparam cpu_opcode_t cpu_inst_opcode_add = 5'd6;
    localparam cpu_opcode_t cpu_inst_opcode_sub = 5'd7;
    localparam cpu_opcode_t cpu_inst_opcode_mul = 5'd8;
    localparam cpu_opcode_t cpu_inst_opcode_div = 5'd9;
    localparam cpu_opcode_t cpu_inst_opcode_and = 5'd10;
    localparam cpu_opcode_t cpu_inst_opcode_or  = 5'd11;
    localparam cpu_opcode_t cpu_inst_opcode_xor = 5'd12;
    localparam cpu_opcode_t cpu_inst_opcode_out = 5'd13;
    localparam cpu_opcode_t cpu_inst_opcode_imp = 5'd14;
    localparam cpu_opcode_t cpu_inst_opcode_ilt = 5'd15;
    localparam cpu_opcode_t cpu_inst_opcode_ieq = 5'd16;
    localparam cpu_opcode_t cpu_inst_opcode_igt = 5'd17;
    localparam cpu_opcode_t cpu_inst_opcode_inc = 5'd18;
    localparam cpu_opcode_t cpu_inst_opcode_dec = 5'd19;

    localparam cpu_len_t cpu_len_imm = cpu_len_t'(cpu_inst_max_len);
    localparam cpu_len_t cpu_len_jmp = cpu_len_t'(cpu_inst_opcode_sz + cpu_inst_immop_sz);
    localparam cpu_len_t cpu_len_alu = cpu_len_t'(cpu_inst_opcode_sz + 2 * cpu_inst_regop_sz);
    localparam cpu_len_t cpu_len_one = cpu_len_t'(cpu_inst_opcode_sz + cpu_inst_regop_sz);

    function automatic cpu_len_t cpu_inst_len(input cpu_opcode_t op);
        return (op == cpu_inst_opcode_imm) ? cpu_len_imm
             : (op inside {cpu_inst_opcode_jmp, cpu_inst_opcode_jlt, cpu_inst_opcode_jeq,
                           cpu_inst_opcode_jgt}) ? cpu_len_jmp
             : (op inside {cpu_inst_opcode_add, cpu_inst_opcode_sub, cpu_inst_opcode_mul,
                           cpu_inst_opcode_div, cpu_inst_opcode_and, cpu_inst_opcode_or,
                           cpu_inst_opcode_xor}) ? cpu_len_alu
             : (op inside {cpu_inst_opcode_out, cpu_inst_opcode_imp, cpu_inst_opcode_ilt,
                           cpu_inst_opcode_ieq, cpu_inst_opcode_igt, cpu_inst_opcode_inc,
                           cpu_inst_opcode_dec}) ? cpu_len_one
             : '0;
    endfunction
endpackage

// File: rtl/cpu_encoder_if.sv
// cpu_encoder_if: instruction input (in_*) and code word output (out_*) valid/ready buses; slave = encoder, master = loader/code store side
interface cpu_encoder_if;
    import cpu_pkg::*;
    logic                         in_valid;
    logic                         in_ready;
    cpu_opcode_t                  in_opcode;
    logic [cpu_inst_regop_sz-1:0] in_regop1;
    logic [cpu_inst_regop_sz-1:0] in_regop2;
    logic [cpu_inst_immop_sz-1:0] in_immop1;
    logic                         out_valid;
    logic                         out_ready;
    logic [cpu_code_sz-1:0]       out_data;
    modport slave (
        input  in_valid, in_opcode, in_regop1, in_regop2, in_immop1, out_ready,
        output in_ready, out_valid, out_data
    );
    modport master (
        output in_valid, in_opcode, in_regop1, in_regop2, in_immop1, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/cpu_encoder_field_pack.sv
// cpu_encoder_field_pack: opcode/regop1/regop2/immop1 in -> pack_bits (LSB-first fields, zero above len), len, known out
module cpu_encoder_field_pack
    import cpu_pkg::*;
(
    input  cpu_opcode_t                  opcode,
    input  logic [cpu_inst_regop_sz-1:0] regop1,
    input  logic [cpu_inst_regop_sz-1:0] regop2,
    input  logic [cpu_inst_immop_sz-1:0] immop1,
    output logic [cpu_inst_max_len-1:0]  pack_bits,
    output cpu_len_t                     len,
    output logic                         known
);
    always_comb begin
        len = cpu_inst_len(opcode);
        known = len != '0;
        pack_bits = (len == cpu_len_imm) ? cpu_inst_max_len'({immop1, regop1, opcode})
                  : (len == cpu_len_jmp) ? cpu_inst_max_len'({immop1, opcode})
                  : (len == cpu_len_alu) ? cpu_inst_max_len'({regop2, regop1, opcode})
                  : (len == cpu_len_one) ? cpu_inst_max_len'({regop1, opcode})
                  : '0;
    end
endmodule

// File: rtl/cpu_encoder.sv
// cpu_encoder: packs instructions from bus.in_* into a bit buffer and emits code words on bus.out_*; flush pads the tail, pc = next bit address, flush_done/err pulses
module cpu_encoder
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_encoder_if.slave         bus,
    input  logic                 flush,
    output logic [cpu_pc_sz-1:0] pc,
    output logic                 flush_done,
    output logic                 err
);
    localparam int WORD = cpu_code_sz;
    localparam int BW = WORD + cpu_inst_max_len;
    localparam int FW = $clog2(BW + 1);
    localparam logic [FW-1:0] WORD_F = FW'(WORD);
    localparam logic [cpu_pc_sz-1:0] PC_MASK = cpu_pc_sz'(WORD - 1);

    cpu_enc_state_e             state_q, state_d;
    logic [BW-1:0]              bits_q, bits_d, bits_s;
    logic [FW-1:0]              fill_q, fill_d, fill_s;
    logic [cpu_pc_sz-1:0]       pc_q, pc_d;
    logic                       err_q, err_d, flush_done_q, flush_done_d;
    logic [cpu_inst_max_len-1:0] pack_bits;
    cpu_len_t                   len;
    logic                       known, in_fire, out_fire;

    cpu_encoder_field_pack u_pack (
        .opcode    (bus.in_opcode),
        .regop1    (bus.in_regop1),
        .regop2    (bus.in_regop2),
        .immop1    (bus.in_immop1),
        .pack_bits (pack_bits),
        .len       (len),
        .known     (known)
    );

    assign bus.in_ready  = state_q == ENC_RUN && fill_q < WORD_F;
    assign bus.out_valid = fill_q >= WORD_F || (state_q == ENC_FLUSH && fill_q != '0);
    assign bus.out_data  = bits_q[WORD-1:0];
    assign pc            = pc_q;
    assign err           = err_q;
    assign flush_done    = flush_done_q;

    always_comb begin
        in_fire = bus.in_valid && bus.in_ready;
        out_fire = bus.out_valid && bus.out_ready;
        bits_s = out_fire ? bits_q >> WORD : bits_q;
        fill_s = out_fire ? (fill_q >= WORD_F ? fill_q - WORD_F : '0) : fill_q;
        bits_d = bits_s;
        fill_d = fill_s;
        pc_d = pc_q;
        state_d = state_q;
        err_d = in_fire && !known;
        flush_done_d = 1'b0;
        if (in_fire && known) begin
            bits_d = bits_s | (BW'(pack_bits) << fill_s);
            fill_d = fill_s + FW'(len);
            pc_d = pc_q + cpu_pc_sz'(len);
        end else if (!in_fire && flush && state_q == ENC_RUN) begin
            state_d = ENC_FLUSH;
            pc_d = (pc_q + PC_MASK) & ~PC_MASK;
        end
        if (state_q == ENC_FLUSH && fill_s == '0) begin
            state_d = ENC_RUN;
            flush_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENC_RUN;
            bits_q <= '0;
            fill_q <= '0;
            pc_q <= '0;
            err_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q <= bits_d;
            fill_q <= fill_d;
            pc_q <= pc_d;
            err_q <= err_d;
            flush_done_q <= flush_done_d;
        end
    end
endmodule
